// File: rtl/seg_disp_arbiter_pkg.sv
// Shared types and helpers for the seg_led display arbiter.
//   state_t    : arbiter FSM encoding (IDLE/SHOW/BLANK)
//   pick_t     : result of a round-robin scan (valid + winning source)
//   src_onehot : source index -> one-hot grant vector
//   rr_pick    : round-robin winner, scanning ptr+1, ptr+2, ptr (mod NREQ)
package seg_disp_arbiter_pkg;
  localparam int NREQ = 3;
  localparam int DW   = 20;
  localparam int PW   = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  typedef logic [1:0] src_t;

  typedef struct packed {
    logic vld;
    src_t idx;
  } pick_t;

  function automatic logic [NREQ-1:0] src_onehot(input src_t s);
    logic [NREQ-1:0] oh;
    case (s)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      default: oh = 3'b100;
    endcase
    return oh;
  endfunction

  function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input src_t ptr);
    src_t  a, b, c;
    pick_t p;
    // Scan order starts just after the last owner so it loses ties.
    case (ptr)
      2'd0:    begin a = 2'd1; b = 2'd2; c = 2'd0; end
      2'd1:    begin a = 2'd2; b = 2'd0; c = 2'd1; end
      default: begin a = 2'd0; b = 2'd1; c = 2'd2; end
    endcase
    p = '0;
    if      (|(req & src_onehot(a))) p = '{vld: 1'b1, idx: a};
    else if (|(req & src_onehot(b))) p = '{vld: 1'b1, idx: b};
    else if (|(req & src_onehot(c))) p = '{vld: 1'b1, idx: c};
    return p;
  endfunction
endpackage

// File: rtl/seg_disp_arbiter_if.sv
// Requester/driver bundle of the display arbiter.
//   req/data/point/sign : per-source request level and display payload
//   gnt                 : one-hot grant back to the sources
//   data_o/point_o/sign_o/en_o : to the seg_led driver
//   busy                : arbiter is in SHOW or BLANK
// slave = arbiter side, master = requesters/driver side.
interface seg_disp_arbiter_if;
  import seg_disp_arbiter_pkg::*;

  logic [NREQ-1:0]         req;
  logic [NREQ-1:0][DW-1:0] data;
  logic [NREQ-1:0][PW-1:0] point;
  logic [NREQ-1:0]         sign;
  logic [NREQ-1:0]         gnt;
  logic [DW-1:0]           data_o;
  logic [PW-1:0]           point_o;
  logic                    sign_o;
  logic                    en_o;
  logic                    busy;

  modport slave  (input  req, data, point, sign,
                  output gnt, data_o, point_o, sign_o, en_o, busy);
  modport master (output req, data, point, sign,
                  input  gnt, data_o, point_o, sign_o, en_o, busy);
endinterface

// File: rtl/seg_disp_arbiter_ms_tick.sv
// 1 ms tick generator.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear, counter restarts at 0 next cycle
//   tick       : one-cycle pulse while the counter sits at MS_CNT-1
module ms_tick_gen #(
  parameter int MS_CNT = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = (MS_CNT > 1) ? $clog2(MS_CNT) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(MS_CNT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (tick)  cnt <= '0;
    else            cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/seg_disp_arbiter.sv
// Round-robin owner of the single 6-digit seg_led driver.
//   clk, rst_n : clock, async active-low reset
//   bus        : seg_disp_arbiter_if.slave (requests/payload in, grant and
//                driver signals out)
// An owner is shown for DWELL_MS, rotating only if someone else waits; the
// display is blanked for BLANK_MS between owners. ptr doubles as the current
// owner index, since the owner is always the last round-robin winner.
module seg_disp_arbiter
  import seg_disp_arbiter_pkg::*;
#(
  parameter int MS_CNT   = 50000,
  parameter int DWELL_MS = 1000,
  parameter int BLANK_MS = 50
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_disp_arbiter_if.slave  bus
);
  localparam int MW = 16;

  state_t          state, state_nx;
  src_t            ptr;
  pick_t           pick;
  logic            grant;
  logic            tick;
  logic            state_chg;
  logic            dwell_done, blank_done;
  logic            owner_req, others_req;
  logic [MW-1:0]   ms_cnt;

  assign pick       = rr_pick(bus.req, ptr);
  assign owner_req  = |(bus.req &  src_onehot(ptr));
  assign others_req = |(bus.req & ~src_onehot(ptr));
  assign dwell_done = tick && (ms_cnt == MW'(DWELL_MS - 1));
  assign blank_done = tick && (ms_cnt == MW'(BLANK_MS - 1));
  assign state_chg  = (state_nx != state);

  // Both timebases restart on every state entry so SHOW/BLANK are exact.
  ms_tick_gen #(.MS_CNT(MS_CNT)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_chg),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          ms_cnt <= '0;
    else if (state_chg || state == IDLE) ms_cnt <= '0;
    else if (tick)                       ms_cnt <= (state == SHOW && dwell_done) ? '0 : ms_cnt + MW'(1);
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 2'd2;
    end else begin
      state <= state_nx;
      if (grant) ptr <= pick.idx;
    end
  end

  // FSM: next state. Owner drop wins over dwell expiry, so a coincident
  // drop and expiry produce a single BLANK.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    case (state)
      IDLE: if (pick.vld) begin
        state_nx = SHOW;
        grant    = 1'b1;
      end
      SHOW: begin
        if (!owner_req)                     state_nx = BLANK;
        else if (dwell_done && others_req)  state_nx = BLANK;
      end
      BLANK: if (blank_done) begin
        if (pick.vld) begin
          state_nx = SHOW;
          grant    = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM: outputs (decoded from registered state/owner)
  always_comb begin
    bus.gnt  = (state == SHOW) ? src_onehot(ptr) : '0;
    bus.en_o = (state == SHOW);
    bus.busy = (state != IDLE);
  end

  // Payload tracks the owner live while shown and freezes otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_o  <= '0;
      bus.point_o <= '0;
      bus.sign_o  <= 1'b0;
    end else if (state == SHOW) begin
      case (ptr)
        2'd0: begin
          bus.data_o <= bus.data[0]; bus.point_o <= bus.point[0]; bus.sign_o <= bus.sign[0];
        end
        2'd1: begin
          bus.data_o <= bus.data[1]; bus.point_o <= bus.point[1]; bus.sign_o <= bus.sign[1];
        end
        default: begin
          bus.data_o <= bus.data[2]; bus.point_o <= bus.point[2]; bus.sign_o <= bus.sign[2];
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seg_disp_arbiter.sv
module tb_seg_disp_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;

  seg_disp_arbiter_if bus();

  seg_disp_arbiter #(.MS_CNT(10), .DWELL_MS(3), .BLANK_MS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [2:0]  req;
    logic [19:0] d0;
    int          adv;
    logic [2:0]  gnt;
    bit          en;
    bit          bsy;
    logic [19:0] dat;
    logic [5:0]  pt;
    bit          sg;
  } vec_t;

  vec_t vq[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic add(input bit rst, input logic [2:0] req, input int d0, input int adv,
                     input logic [2:0] gnt, input bit en, input bit bsy,
                     input int dat, input logic [5:0] pt, input bit sg);
    vec_t v;
    v.rst = rst; v.req = req; v.d0 = 20'(d0); v.adv = adv;
    v.gnt = gnt; v.en = en; v.bsy = bsy; v.dat = 20'(dat); v.pt = pt; v.sg = sg;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [2:0] gnt, input bit en, input bit bsy,
                       input logic [19:0] dat, input logic [5:0] pt, input bit sg);
    n_vec++;
    if (bus.gnt !== gnt || bus.en_o !== en || bus.busy !== bsy ||
        bus.data_o !== dat || bus.point_o !== pt || bus.sign_o !== sg) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b en=%b busy=%b data=%0d point=%h sign=%b, want gnt=%b en=%b busy=%b data=%0d point=%h sign=%b",
               nm, bus.gnt, bus.en_o, bus.busy, bus.data_o, bus.point_o, bus.sign_o,
               gnt, en, bsy, dat, pt, sg);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bus.req     = '0;
    bus.data[0] = 20'd100;
    bus.data[1] = 20'd200;
    bus.data[2] = 20'd300;
    bus.point[0] = 6'h01;
    bus.point[1] = 6'h02;
    bus.point[2] = 6'h04;
    bus.sign     = 3'b010;

    // single source, live data tracking, drop -> blank -> idle
    add(1, 3'b001, 12345, 1,  3'b001, 1, 1, 0,     6'h00, 0);
    add(0, 3'b001, 12345, 1,  3'b001, 1, 1, 12345, 6'h01, 0);
    add(0, 3'b001, 42,    1,  3'b001, 1, 1, 42,    6'h01, 0);
    add(0, 3'b001, 42,    5,  3'b001, 1, 1, 42,    6'h01, 0);
    add(0, 3'b000, 42,    1,  3'b000, 0, 1, 42,    6'h01, 0);
    add(0, 3'b000, 42,    19, 3'b000, 0, 1, 42,    6'h01, 0);
    add(0, 3'b000, 42,    1,  3'b000, 0, 0, 42,    6'h01, 0);
    // two requesters: 30 shown, 20 blank, then source 1
    add(1, 3'b011, 100, 1,  3'b001, 1, 1, 0,   6'h00, 0);
    add(0, 3'b011, 100, 29, 3'b001, 1, 1, 100, 6'h01, 0);
    add(0, 3'b011, 100, 1,  3'b000, 0, 1, 100, 6'h01, 0);
    add(0, 3'b011, 100, 19, 3'b000, 0, 1, 100, 6'h01, 0);
    add(0, 3'b011, 100, 1,  3'b010, 1, 1, 100, 6'h01, 0);
    add(0, 3'b011, 100, 1,  3'b010, 1, 1, 200, 6'h02, 1);
    // three requesters: 0,1,2,0
    add(1, 3'b111, 100, 1,  3'b001, 1, 1, 0,   6'h00, 0);
    add(0, 3'b111, 100, 30, 3'b000, 0, 1, 100, 6'h01, 0);
    add(0, 3'b111, 100, 20, 3'b010, 1, 1, 100, 6'h01, 0);
    add(0, 3'b111, 100, 1,  3'b010, 1, 1, 200, 6'h02, 1);
    add(0, 3'b111, 100, 49, 3'b100, 1, 1, 200, 6'h02, 1);
    add(0, 3'b111, 100, 1,  3'b100, 1, 1, 300, 6'h04, 0);
    add(0, 3'b111, 100, 28, 3'b100, 1, 1, 300, 6'h04, 0);
    add(0, 3'b111, 100, 1,  3'b000, 0, 1, 300, 6'h04, 0);
    add(0, 3'b111, 100, 20, 3'b001, 1, 1, 300, 6'h04, 0);
    add(0, 3'b111, 100, 1,  3'b001, 1, 1, 100, 6'h01, 0);
    // drop at SHOW cycle 12 -> blank 20 -> idle
    add(1, 3'b001, 100, 1,  3'b001, 1, 1, 0,   6'h00, 0);
    add(0, 3'b001, 100, 12, 3'b001, 1, 1, 100, 6'h01, 0);
    add(0, 3'b000, 100, 1,  3'b000, 0, 1, 100, 6'h01, 0);
    add(0, 3'b000, 100, 19, 3'b000, 0, 1, 100, 6'h01, 0);
    add(0, 3'b000, 100, 1,  3'b000, 0, 0, 100, 6'h01, 0);
    // drop coinciding with dwell expiry: one blank only
    add(1, 3'b011, 100, 1,  3'b001, 1, 1, 0,   6'h00, 0);
    add(0, 3'b011, 100, 29, 3'b001, 1, 1, 100, 6'h01, 0);
    add(0, 3'b010, 100, 1,  3'b000, 0, 1, 100, 6'h01, 0);
    add(0, 3'b010, 100, 19, 3'b000, 0, 1, 100, 6'h01, 0);
    add(0, 3'b010, 100, 1,  3'b010, 1, 1, 100, 6'h01, 0);
    // lone requester after blank is re-granted
    add(1, 3'b011, 100, 1,  3'b001, 1, 1, 0,   6'h00, 0);
    add(0, 3'b011, 100, 30, 3'b000, 0, 1, 100, 6'h01, 0);
    add(0, 3'b001, 100, 20, 3'b001, 1, 1, 100, 6'h01, 0);
    // non-owner pulse ignored mid-dwell; dwell restart timing
    add(1, 3'b001, 100, 1,  3'b001, 1, 1, 0,   6'h00, 0);
    add(0, 3'b001, 100, 5,  3'b001, 1, 1, 100, 6'h01, 0);
    add(0, 3'b011, 100, 5,  3'b001, 1, 1, 100, 6'h01, 0);
    add(0, 3'b001, 100, 20, 3'b001, 1, 1, 100, 6'h01, 0);
    add(0, 3'b001, 100, 30, 3'b001, 1, 1, 100, 6'h01, 0);
    add(0, 3'b011, 100, 29, 3'b001, 1, 1, 100, 6'h01, 0);
    add(0, 3'b011, 100, 1,  3'b000, 0, 1, 100, 6'h01, 0);

    // reset asserted: outputs clear without a clock edge
    #2 rst_n = 1'b0;
    #1 check("reset_async", 3'b000, 0, 0, 20'd0, 6'h00, 0);
    step(2);

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].rst) do_reset();
      bus.req     = vq[i].req;
      bus.data[0] = vq[i].d0;
      step(vq[i].adv);
      check($sformatf("vec%0d", i), vq[i].gnt, vq[i].en, vq[i].bsy, vq[i].dat, vq[i].pt, vq[i].sg);
    end

    // reset mid-SHOW of source 1, then ptr restarts at 2
    do_reset();
    bus.data[0] = 20'd100;
    bus.req = 3'b010;
    step(6);
    check("show_src1", 3'b010, 1, 1, 20'd200, 6'h02, 1);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_show", 3'b000, 0, 0, 20'd0, 6'h00, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.req = 3'b110;
    step(1);
    check("post_reset_gnt", 3'b010, 1, 1, 20'd0, 6'h00, 0);
    step(1);
    check("post_reset_data", 3'b010, 1, 1, 20'd200, 6'h02, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
